// File: rtl/load_store_unit.sv
// load_store_unit: req/ack data-memory access stage with byte-lane store formatting,
// sign/zero-extended load alignment, misalignment and timeout detection.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          addr_q, wdata_q, rdata_q, rdata_d, ld_fmt;
   logic [1:0]           size_q;
   logic                 req_q, uns_q, we_q, err_q, err_d;
   logic                 start, misaligned, timeout;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;

   // only a rising edge of the combined request starts an access, and only when idle
   assign start      = (rd_en | wr_en) & ~req_q & (state_q == IDLE);
   assign misaligned = (size == 2'b01 & addr[0]) | (size[1] & |addr[1:0]);
   assign timeout    = cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   always_comb begin
      ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_fmt  = size_q[1] ? mem_rdata
              : size_q[0] ? {{16{ld_half[15] & ~uns_q}}, ld_half}
              : {{24{ld_byte[7] & ~uns_q}}, ld_byte};
   end

   // ack is checked before timeout so an ack on the final cycle still succeeds
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (start) begin
            cnt_d   = '0;
            err_d   = misaligned;
            state_d = misaligned ? DONE : REQ;
            rdata_d = misaligned ? '0 : rdata_q;
         end
         REQ: if (mem_ack) begin
            state_d = DONE;
            rdata_d = we_q ? rdata_q : ld_fmt;
         end else if (timeout) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
         end else cnt_d = cnt_q + 1'b1;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= rd_en | wr_en;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            uns_q   <= ld_unsigned;
            we_q    <= wr_en;
         end
      end
   end

   assign rdata     = rdata_q;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign err       = done & err_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_req   = state_q == REQ;
   assign mem_we    = mem_req & we_q;
   assign mem_wstrb = !we_q     ? 4'b0000
                    : size_q[1] ? 4'b1111
                    : size_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011)
                    : 4'b0001 << addr_q[1:0];
   assign mem_wdata = size_q[1] ? wdata_q : size_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
endmodule
